// File: rtl/s5_pll_lock_mgr_if.sv
// PLL reset/lock handshake between the lock manager (master) and the PLL-side
// consumer of its status (slave).
interface s5_pll_lock_mgr_if;
    logic       pll_locked;
    logic       sw_reset_req;
    logic       pll_rst;
    logic       ready;
    logic [7:0] timeout_cnt;
    logic [7:0] lock_loss_cnt;

    modport master (
        input  pll_locked,
        input  sw_reset_req,
        output pll_rst,
        output ready,
        output timeout_cnt,
        output lock_loss_cnt
    );

    modport slave (
        output pll_locked,
        output sw_reset_req,
        input  pll_rst,
        input  ready,
        input  timeout_cnt,
        input  lock_loss_cnt
    );
endinterface

// File: rtl/s5_pll_lock_mgr.sv
// PLL reset sequencer and lock monitor running on the PLL reference clock:
// pulses the PLL reset, qualifies lock stability and retries on timeout or lock loss.
module s5_pll_lock_mgr #(
    parameter int unsigned RST_HOLD_CYCLES     = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned SYNC_STAGES         = 2
) (
    input  logic                 refclk,
    input  logic                 rst_n,
    s5_pll_lock_mgr_if.master    pll
);

    localparam int unsigned MAX_A  = (RST_HOLD_CYCLES > LOCK_STABLE_CYCLES) ?
                                     RST_HOLD_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned MAX_C  = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned CNT_W  = $clog2(MAX_C) + 1;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    localparam logic [1:0] StResetPll    = 2'd0;
    localparam logic [1:0] StWaitLock    = 2'd1;
    localparam logic [1:0] StStableCheck = 2'd2;
    localparam logic [1:0] StRun         = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   pll_rst_q, ready_q;
    logic [7:0]             timeout_cnt_q, lock_loss_cnt_q;
    logic                   timeout_evt, lock_loss_evt;

    // pll_locked is asynchronous to refclk; only the last stage is ever used.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll.pll_locked};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + CNT_W'(1);
        timeout_evt   = 1'b0;
        lock_loss_evt = 1'b0;
        if (pll.sw_reset_req) begin
            // Request overrides any simultaneous timeout or lock loss.
            state_d = StResetPll;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StResetPll: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = StWaitLock;
                        cnt_d   = '0;
                    end
                end
                StWaitLock: begin
                    if (locked_s) begin
                        state_d = StStableCheck;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d     = StResetPll;
                        cnt_d       = '0;
                        timeout_evt = 1'b1;
                    end
                end
                StStableCheck: begin
                    if (!locked_s) begin
                        state_d = StWaitLock;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = StRun;
                        cnt_d   = '0;
                    end
                end
                StRun: begin
                    cnt_d = '0;
                    if (!locked_s) begin
                        state_d       = StResetPll;
                        lock_loss_evt = 1'b1;
                    end
                end
                default: begin
                    state_d = StResetPll;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StResetPll;
            cnt_q           <= '0;
            pll_rst_q       <= 1'b1;
            ready_q         <= 1'b0;
            timeout_cnt_q   <= '0;
            lock_loss_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pll_rst_q <= (state_d == StResetPll);
            ready_q   <= (state_d == StRun);
            if (timeout_evt && (timeout_cnt_q != 8'hff)) begin
                timeout_cnt_q <= timeout_cnt_q + 8'd1;
            end
            if (lock_loss_evt && (lock_loss_cnt_q != 8'hff)) begin
                lock_loss_cnt_q <= lock_loss_cnt_q + 8'd1;
            end
        end
    end

    assign pll.pll_rst       = pll_rst_q;
    assign pll.ready         = ready_q;
    assign pll.timeout_cnt   = timeout_cnt_q;
    assign pll.lock_loss_cnt = lock_loss_cnt_q;

endmodule

// File: tb/tb_s5_pll_lock_mgr.sv
// Randomized bench for s5_pll_lock_mgr: scenario tasks predict output events
// (edge index plus output/counter values) into a queue that a monitor drains.
module tb_s5_pll_lock_mgr;
    localparam int HOLD   = 4;
    localparam int STABLE = 8;
    localparam int TMO    = 32;
    localparam int SYNC   = 2;

    logic refclk = 1'b0;
    logic rst_n  = 1'b0;
    s5_pll_lock_mgr_if bus();

    s5_pll_lock_mgr #(
        .RST_HOLD_CYCLES    (HOLD),
        .LOCK_STABLE_CYCLES (STABLE),
        .LOCK_TIMEOUT_CYCLES(TMO),
        .SYNC_STAGES        (SYNC)
    ) dut (
        .refclk(refclk),
        .rst_n (rst_n),
        .pll   (bus)
    );

    always #5 refclk = ~refclk;

    int cyc = 0;
    always @(posedge refclk) cyc <= cyc + 1;

    typedef struct {
        int at;
        bit rst;
        bit rdy;
        int tc;
        int lc;
    } ev_t;

    ev_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  exp_tc  = 0;
    int  exp_lc  = 0;

    // Any change of outputs or counters is an event that must match the next prediction.
    logic [17:0] prev_key;
    always @(negedge refclk) begin
        logic [17:0] key;
        ev_t e;
        key = {bus.pll_rst, bus.ready, bus.timeout_cnt, bus.lock_loss_cnt};
        if (rst_n && key !== prev_key) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event cyc=%0d got rst=%b rdy=%b tc=%0d lc=%0d, required no change",
                         cyc, bus.pll_rst, bus.ready, bus.timeout_cnt, bus.lock_loss_cnt);
            end else begin
                e = exp_q.pop_front();
                if (cyc != e.at || bus.pll_rst !== e.rst || bus.ready !== e.rdy ||
                    bus.timeout_cnt !== 8'(e.tc) || bus.lock_loss_cnt !== 8'(e.lc)) begin
                    n_fail++;
                    $display("FAIL event got cyc=%0d rst=%b rdy=%b tc=%0d lc=%0d required cyc=%0d rst=%b rdy=%b tc=%0d lc=%0d",
                             cyc, bus.pll_rst, bus.ready, bus.timeout_cnt, bus.lock_loss_cnt,
                             e.at, e.rst, e.rdy, e.tc, e.lc);
                end
            end
        end
        prev_key = key;
    end

    task automatic check(input string name, input int got, input int req);
        n_tests++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s got %0d required %0d", name, got, req);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) step();
    endtask

    task automatic push(input int at, input bit r, input bit y);
        ev_t e;
        e.at  = at;
        e.rst = r;
        e.rdy = y;
        e.tc  = exp_tc;
        e.lc  = exp_lc;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pll_rst"}, int'(bus.pll_rst), 1);
        check({tag, "_ready"}, int'(bus.ready), 0);
        check({tag, "_timeout_cnt"}, int'(bus.timeout_cnt), 0);
        check({tag, "_lock_loss_cnt"}, int'(bus.lock_loss_cnt), 0);
    endtask

    // Returns f: edge on which pll_rst falls (WAIT_LOCK entered).
    task automatic release_reset(output int f);
        step();
        rst_n = 1'b1;
        f = cyc + HOLD;
        push(f, 1'b0, 1'b0);
    endtask

    // From WAIT entry f, raise lock; r is the edge on which ready rises.
    task automatic do_lock(input int f, output int r);
        int s;
        wait_until(f + int'($urandom_range(0, TMO - 3)));
        bus.pll_locked = 1'b1;
        s = cyc + 1;
        r = s + (SYNC + 1 + STABLE) - 1;
        push(r, 1'b0, 1'b1);
        wait_until(r);
    endtask

    task automatic do_timeouts(input int f, input int n, output int fo);
        for (int i = 0; i < n; i++) begin
            exp_tc = sat(exp_tc);
            push(f + TMO, 1'b1, 1'b0);
            f = f + TMO + HOLD;
            push(f, 1'b0, 1'b0);
        end
        fo = f;
        wait_until(fo);
    endtask

    task automatic do_loss(input int r, output int fo);
        int d;
        wait_until(r + int'($urandom_range(0, 15)));
        bus.pll_locked = 1'b0;
        d = cyc + 1;
        exp_lc = sat(exp_lc);
        push(d + SYNC, 1'b1, 1'b0);
        fo = d + SYNC + HOLD;
        push(fo, 1'b0, 1'b0);
    endtask

    // Lock drop and sw_reset_req seen by the manager on the same edge.
    task automatic do_sw_loss(input int r, output int fo);
        int d;
        int h;
        wait_until(r + int'($urandom_range(0, 15)));
        bus.pll_locked = 1'b0;
        d = cyc + 1;
        h = int'($urandom_range(1, 4));
        push(d + SYNC, 1'b1, 1'b0);
        fo = d + SYNC + h + HOLD - 1;
        push(fo, 1'b0, 1'b0);
        wait_until(d + SYNC - 1);
        bus.sw_reset_req = 1'b1;
        wait_until(d + SYNC - 1 + h);
        bus.sw_reset_req = 1'b0;
    endtask

    task automatic do_sw_wait(input int f, output int fo);
        int e;
        int h;
        wait_until(f + int'($urandom_range(0, 25)));
        bus.sw_reset_req = 1'b1;
        e = cyc + 1;
        h = int'($urandom_range(1, 4));
        push(e, 1'b1, 1'b0);
        fo = e + h + HOLD - 1;
        push(fo, 1'b0, 1'b0);
        wait_until(e + h - 1);
        bus.sw_reset_req = 1'b0;
        wait_until(fo);
    endtask

    // Lock pulse of p sampled cycles (p < STABLE+1) never qualifies; timeout restarts from the drop.
    task automatic do_unstable(input int f, output int fo);
        int s;
        int p;
        int back;
        wait_until(f + int'($urandom_range(0, 20)));
        bus.pll_locked = 1'b1;
        s = cyc + 1;
        p = int'($urandom_range(1, STABLE));
        wait_until(s + p - 1);
        bus.pll_locked = 1'b0;
        back = s + p + SYNC;
        exp_tc = sat(exp_tc);
        push(back + TMO, 1'b1, 1'b0);
        fo = back + TMO + HOLD;
        push(fo, 1'b0, 1'b0);
        wait_until(fo);
    endtask

    task automatic do_stable_reset(input int f);
        int s;
        wait_until(f + int'($urandom_range(0, 20)));
        bus.pll_locked = 1'b1;
        s = cyc + 1;
        wait_until(s + SYNC + 1 + int'($urandom_range(0, 5)));
        check("queue_drained_before_rst", exp_q.size(), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        exp_tc = 0;
        exp_lc = 0;
        bus.pll_locked = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        int f;
        int r;
        bus.pll_locked   = 1'b0;
        bus.sw_reset_req = 1'b0;
        repeat (3) step();
        check_reset_values("por");

        release_reset(f);
        do_timeouts(f, 1, f);
        do_lock(f, r);
        do_loss(r, f);
        do_lock(f, r);
        do_sw_loss(r, f);
        do_lock(f, r);
        do_loss(r, f);
        for (int i = 0; i < 3; i++) do_unstable(f, f);
        do_sw_wait(f, f);

        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 4))
                0: do_timeouts(f, int'($urandom_range(1, 3)), f);
                1: begin do_lock(f, r); do_loss(r, f); end
                2: do_unstable(f, f);
                3: do_sw_wait(f, f);
                default: begin do_lock(f, r); do_sw_loss(r, f); end
            endcase
        end

        do_timeouts(f, 300, f);
        check("timeout_saturated", int'(bus.timeout_cnt), 255);
        do_lock(f, r);
        do_loss(r, f);

        do_stable_reset(f);
        release_reset(f);
        do_lock(f, r);
        repeat (5) step();
        check("queue_drained_at_end", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
